// File: rtl/adc_period_meter.sv
// Squares a sampled ADC waveform with a hysteresis comparator and measures the
// sys_clk distance between rising crossings. Outputs the average of every 2^AVG_LOG2 periods.
module adc_period_meter #(
    parameter int DATA_W   = 13,
    parameter int CNT_W    = 32,
    parameter int AVG_LOG2 = 3,
    parameter int HYST     = 64,
    parameter int TIMEOUT  = 26_000_000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] i_adc_data,
    input  logic              i_adc_valid,
    input  logic [DATA_W-1:0] i_mid,
    output logic              o_level,
    output logic [CNT_W-1:0]  o_period,
    output logic              o_period_valid,
    output logic              o_timeout
);

    localparam int TH_W  = DATA_W + 1;
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int N_W   = AVG_LOG2 + 1;

    localparam logic [TH_W-1:0]  SAMPLE_MAX = {1'b0, {DATA_W{1'b1}}};
    localparam logic [TH_W-1:0]  HYST_C     = TH_W'(HYST);
    localparam logic [CNT_W-1:0] CYC_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [N_W-1:0]   N_FULL     = N_W'(1 << AVG_LOG2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEAS = 1'b1;

    logic [0:0]       r_state;
    logic             r_level;
    logic [CNT_W-1:0] r_cyc;
    logic [ACC_W-1:0] r_acc;
    logic [N_W-1:0]   r_n;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_timeout;

    logic [TH_W-1:0] w_mid_ext;
    logic [TH_W-1:0] w_sample;
    logic [TH_W-1:0] w_hi_sum;
    logic [TH_W-1:0] w_th_hi;
    logic [TH_W-1:0] w_th_lo;
    logic            w_rise;
    logic            w_fall;
    logic            w_timeout_hit;
    logic            w_close;

    // Thresholds are one bit wider than the sample so the clamps can be seen.
    assign w_mid_ext = {1'b0, i_mid};
    assign w_sample  = {1'b0, i_adc_data};
    assign w_hi_sum  = w_mid_ext + HYST_C;
    assign w_th_hi   = (w_hi_sum > SAMPLE_MAX) ? SAMPLE_MAX : w_hi_sum;
    assign w_th_lo   = (w_mid_ext > HYST_C) ? (w_mid_ext - HYST_C) : '0;

    assign w_rise        = i_adc_valid && !r_level && (w_sample >= w_th_hi);
    assign w_fall        = i_adc_valid &&  r_level && (w_sample <= w_th_lo);
    assign w_timeout_hit = (r_cyc >= TIMEOUT_C) && !w_rise;
    // n reaches full one cycle after the closing rise; level is high then, so no rise can collide.
    assign w_close       = (r_state == ST_MEAS) && (r_n == N_FULL);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_level        <= 1'b0;
            r_cyc          <= '0;
            r_acc          <= '0;
            r_n            <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;

            if (w_rise) begin
                r_level <= 1'b1;
            end else if (w_fall) begin
                r_level <= 1'b0;
            end

            // r_cyc is the cycle distance from the last rise: 0 on the event cycle, 1 the next.
            if (w_rise) begin
                r_cyc <= CNT_W'(1);
            end else if (r_cyc != CYC_MAX) begin
                r_cyc <= r_cyc + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= ST_MEAS;
                        r_acc   <= '0;
                        r_n     <= '0;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_acc     <= '0;
                        r_n       <= '0;
                    end
                end
                ST_MEAS: begin
                    if (w_rise) begin
                        r_acc <= r_acc + ACC_W'(r_cyc);
                        r_n   <= r_n + 1'b1;
                    end else if (w_close) begin
                        r_period       <= CNT_W'(r_acc >> AVG_LOG2);
                        r_period_valid <= 1'b1;
                        r_timeout      <= 1'b0;
                        r_acc          <= '0;
                        r_n            <= '0;
                    end else if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                        r_acc     <= '0;
                        r_n       <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level        = r_level;
    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_timeout      = r_timeout;

endmodule
